// File: rtl/operand_stage.sv
// Operand stage: selects source operands with EX/MEM and MEM/WB bypass,
// detects dependences on the instruction currently in EX and inserts a
// one-cycle bubble for them, then registers control and operands for EX.
module operand_stage (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        id_valid,
   input  logic [4:0]  id_rs,
   input  logic [4:0]  id_rt,
   input  logic [4:0]  id_dst,
   input  logic        id_regwr,
   input  logic        id_memrd,
   input  logic [31:0] id_imm,
   input  logic [31:0] regfile_out1,
   input  logic [31:0] regfile_out2,
   input  logic        exmem_regwr,
   input  logic [4:0]  exmem_dst,
   input  logic [31:0] exmem_data,
   input  logic        memwb_regwr,
   input  logic [4:0]  memwb_dst,
   input  logic [31:0] memwb_data,
   input  logic        flush,
   output logic        stall,
   output logic        ex_valid,
   output logic        ex_regwr,
   output logic        ex_memrd,
   output logic [31:0] ex_a,
   output logic [31:0] ex_b,
   output logic [31:0] ex_imm,
   output logic [4:0]  ex_dst,
   output logic [15:0] stall_count
);

   logic        hazard;
   logic        bubble;
   logic [31:0] opnd_a;
   logic [31:0] opnd_b;

   // r0 reads zero; the younger EX/MEM result beats MEM/WB. MEM/WB doubles
   // as the register file write port, so it also closes the write/read gap.
   function automatic logic [31:0] pick (
      input logic [4:0]  idx,
      input logic [31:0] rf,
      input logic        em_wr,
      input logic [4:0]  em_dst,
      input logic [31:0] em_data,
      input logic        mw_wr,
      input logic [4:0]  mw_dst,
      input logic [31:0] mw_data
   );
      if (idx == 5'd0)                     return 32'd0;
      else if (em_wr && (em_dst == idx))   return em_data;
      else if (mw_wr && (mw_dst == idx))   return mw_data;
      else                                 return rf;
   endfunction

   // Operand select and hazard detection; EX results are never bypassed,
   // so any dependence on the instruction in EX costs one bubble.
   always_comb begin
      opnd_a = pick(id_rs, regfile_out1, exmem_regwr, exmem_dst, exmem_data,
                    memwb_regwr, memwb_dst, memwb_data);
      opnd_b = pick(id_rt, regfile_out2, exmem_regwr, exmem_dst, exmem_data,
                    memwb_regwr, memwb_dst, memwb_data);
      hazard = id_valid && ex_valid && ex_regwr && (ex_dst != 5'd0) &&
               ((ex_dst == id_rs) || (ex_dst == id_rt));
      stall  = hazard && !flush;
      bubble = flush || hazard;
   end

   // ID/EX register: bubble clears control and holds operands, else load.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         ex_valid <= 1'b0;
         ex_regwr <= 1'b0;
         ex_memrd <= 1'b0;
         ex_dst   <= 5'd0;
         ex_a     <= 32'd0;
         ex_b     <= 32'd0;
         ex_imm   <= 32'd0;
      end else if (bubble) begin
         ex_valid <= 1'b0;
         ex_regwr <= 1'b0;
         ex_memrd <= 1'b0;
         ex_dst   <= 5'd0;
      end else begin
         ex_valid <= id_valid;
         ex_regwr <= id_regwr && id_valid && (id_dst != 5'd0);
         ex_memrd <= id_memrd && id_valid;
         ex_dst   <= id_dst;
         ex_a     <= opnd_a;
         ex_b     <= opnd_b;
         ex_imm   <= id_imm;
      end
   end

   // Saturating stall-cycle counter.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)
         stall_count <= 16'd0;
      else if (stall && (stall_count != 16'hFFFF))
         stall_count <= stall_count + 16'd1;
   end

endmodule

// File: tb/tb_operand_stage.sv
// Randomized and directed bench for operand_stage against a cycle-level
// behavioural model of the decode-to-EX handoff.
module tb_operand_stage;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        id_valid = 1'b0, id_regwr = 1'b0, id_memrd = 1'b0, flush = 1'b0;
   logic [4:0]  id_rs = '0, id_rt = '0, id_dst = '0;
   logic [31:0] id_imm = '0, regfile_out1 = '0, regfile_out2 = '0;
   logic        exmem_regwr = 1'b0, memwb_regwr = 1'b0;
   logic [4:0]  exmem_dst = '0, memwb_dst = '0;
   logic [31:0] exmem_data = '0, memwb_data = '0;
   logic        stall, ex_valid, ex_regwr, ex_memrd;
   logic [31:0] ex_a, ex_b, ex_imm;
   logic [4:0]  ex_dst;
   logic [15:0] stall_count;

   int n_chk = 0;
   int n_pass = 0;

   // model of the EX-side state
   bit          m_valid, m_regwr, m_memrd;
   int          m_dst;
   logic [31:0] m_a, m_b, m_imm;
   int          m_cnt;
   bit          m_stall;

   operand_stage dut (
      .clk(clk), .rst_n(rst_n), .id_valid(id_valid), .id_rs(id_rs), .id_rt(id_rt),
      .id_dst(id_dst), .id_regwr(id_regwr), .id_memrd(id_memrd), .id_imm(id_imm),
      .regfile_out1(regfile_out1), .regfile_out2(regfile_out2),
      .exmem_regwr(exmem_regwr), .exmem_dst(exmem_dst), .exmem_data(exmem_data),
      .memwb_regwr(memwb_regwr), .memwb_dst(memwb_dst), .memwb_data(memwb_data),
      .flush(flush), .stall(stall), .ex_valid(ex_valid), .ex_regwr(ex_regwr),
      .ex_memrd(ex_memrd), .ex_a(ex_a), .ex_b(ex_b), .ex_imm(ex_imm),
      .ex_dst(ex_dst), .stall_count(stall_count)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
   endtask

   // value a source register should read, following the bypass rules
   function automatic logic [31:0] ref_opnd(input int r, input logic [31:0] rf);
      if (r == 0) return 32'd0;
      if (exmem_regwr && int'(exmem_dst) == r) return exmem_data;
      if (memwb_regwr && int'(memwb_dst) == r) return memwb_data;
      return rf;
   endfunction

   function automatic bit ref_hazard();
      return id_valid && m_valid && m_regwr && m_dst != 0 &&
             (m_dst == int'(id_rs) || m_dst == int'(id_rt));
   endfunction

   task automatic model_reset();
      m_valid = 0; m_regwr = 0; m_memrd = 0; m_dst = 0;
      m_a = 0; m_b = 0; m_imm = 0; m_cnt = 0;
   endtask

   task automatic chk_outputs(input string pfx);
      chk({pfx, ".ex_valid"}, ex_valid, m_valid);
      chk({pfx, ".ex_regwr"}, ex_regwr, m_regwr);
      chk({pfx, ".ex_memrd"}, ex_memrd, m_memrd);
      chk({pfx, ".ex_dst"}, ex_dst, m_dst);
      chk({pfx, ".ex_a"}, ex_a, m_a);
      chk({pfx, ".ex_b"}, ex_b, m_b);
      chk({pfx, ".ex_imm"}, ex_imm, m_imm);
      chk({pfx, ".stall_count"}, stall_count, m_cnt);
   endtask

   // inputs are already driven; check stall in the middle of the low phase
   task automatic pre(input string pfx);
      #1;
      m_stall = ref_hazard() && !flush;
      chk({pfx, ".stall"}, stall, m_stall);
   endtask

   // clock the edge, advance the model, compare registered outputs
   task automatic post(input string pfx);
      bit hz;
      logic [31:0] na, nb;
      hz = ref_hazard();
      na = ref_opnd(id_rs, regfile_out1);
      nb = ref_opnd(id_rt, regfile_out2);
      @(posedge clk);
      if (m_stall && m_cnt < 65535) m_cnt++;
      if (flush || hz) begin
         m_valid = 0; m_regwr = 0; m_memrd = 0; m_dst = 0;
      end else begin
         m_valid = id_valid;
         m_regwr = id_valid && id_regwr && id_dst != 0;
         m_memrd = id_valid && id_memrd;
         m_dst   = id_dst;
         m_a = na; m_b = nb; m_imm = id_imm;
      end
      #1;
      chk_outputs(pfx);
      @(negedge clk);
   endtask

   task automatic cycle(input string pfx);
      pre(pfx);
      post(pfx);
   endtask

   task automatic set_id(input bit v, input int rs, input int rt, input int dst,
                         input bit rw, input bit mr);
      id_valid = v; id_rs = rs[4:0]; id_rt = rt[4:0]; id_dst = dst[4:0];
      id_regwr = rw; id_memrd = mr; id_imm = $urandom;
      regfile_out1 = $urandom; regfile_out2 = $urandom;
   endtask

   initial begin
      model_reset();
      #2;
      chk("rst.ex_valid", ex_valid, 0);
      chk("rst.ex_a", ex_a, 0);
      chk("rst.stall_count", stall_count, 0);
      chk("rst.stall", stall, 0);
      @(negedge clk);
      rst_n = 1'b1;

      // no dependence
      set_id(1, 3, 4, 9, 1, 0);
      regfile_out1 = 32'h11; regfile_out2 = 32'h22;
      cycle("nodep");
      chk("nodep.a", ex_a, 32'h11);
      chk("nodep.b", ex_b, 32'h22);
      chk("nodep.v", ex_valid, 1);

      // bypass priority; id_dst=0 also checks regwr suppression
      set_id(1, 5, 4, 0, 1, 0);
      exmem_regwr = 1; exmem_dst = 5; exmem_data = 32'hAAAA;
      memwb_regwr = 1; memwb_dst = 5; memwb_data = 32'hBBBB;
      cycle("byp_em");
      chk("byp_em.a", ex_a, 32'hAAAA);
      chk("dst0.regwr", ex_regwr, 0);
      exmem_regwr = 0;
      cycle("byp_mw");
      chk("byp_mw.a", ex_a, 32'hBBBB);
      id_rs = 0;
      cycle("byp_r0");
      chk("byp_r0.a", ex_a, 0);
      memwb_regwr = 0;

      // load-use on r7
      set_id(1, 1, 2, 7, 1, 1);
      cycle("lu_prod");
      set_id(1, 7, 2, 0, 1, 0);
      pre("lu_dep");
      chk("lu.stall1", stall, 1);
      post("lu_dep");
      chk("lu.bubble", ex_valid, 0);
      pre("lu_dep2");
      chk("lu.stall0", stall, 0);
      post("lu_dep2");
      chk("lu.loaded", ex_valid, 1);
      chk("lu.count", stall_count, 1);

      // flush beats hazard
      set_id(1, 1, 2, 7, 1, 0);
      cycle("fl_prod");
      set_id(1, 2, 7, 3, 1, 0);
      flush = 1;
      pre("fl");
      chk("fl.stall", stall, 0);
      post("fl");
      chk("fl.valid", ex_valid, 0);
      chk("fl.count", stall_count, 1);
      flush = 0;

      // saturation from a preloaded count
      force dut.stall_count = 16'hFFFE;
      #1;
      release dut.stall_count;
      m_cnt = 16'hFFFE;
      set_id(1, 7, 7, 7, 1, 0);
      for (int i = 0; i < 7; i++) cycle("sat");
      chk("sat.count", stall_count, 16'hFFFF);

      // async reset while EX holds a valid instruction
      set_id(1, 1, 2, 4, 1, 0);
      cycle("ar_load");
      #2;
      rst_n = 1'b0;
      #1;
      model_reset();
      chk("ar.valid", ex_valid, 0);
      chk("ar.a", ex_a, 0);
      chk("ar.count", stall_count, 0);
      chk("ar.stall", stall, 0);
      @(negedge clk);
      rst_n = 1'b1;
      set_id(1, 4, 4, 6, 1, 0);
      cycle("ar_rel");
      chk("ar_rel.valid", ex_valid, 1);

      // randomized traffic over a small register range to force dependences
      for (int i = 0; i < 400; i++) begin
         set_id($urandom_range(3, 0) != 0, $urandom_range(7, 0), $urandom_range(7, 0),
                $urandom_range(7, 0), $urandom_range(1, 0), $urandom_range(1, 0));
         flush       = ($urandom_range(7, 0) == 0);
         exmem_regwr = $urandom_range(1, 0);
         exmem_dst   = $urandom_range(7, 0);
         exmem_data  = $urandom;
         memwb_regwr = $urandom_range(1, 0);
         memwb_dst   = $urandom_range(7, 0);
         memwb_data  = $urandom;
         cycle("rnd");
      end

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule

// File: doc/operand_stage.md
OPERAND_STAGE -- requirements
Module: operand_stage

Interface
REQ-001 clk  in  1  system clock; all state updates on rising edge.
REQ-002 rst_n  in  1  asynchronous, active-low reset; clears all state immediately on assertion.
REQ-003 id_valid  in  1  decode slot holds a real instruction.
REQ-004 id_rs, id_rt  in  5 each  source register indices (also drive the register file read ports).
REQ-005 id_dst  in  5  destination register index.
REQ-006 id_regwr, id_memrd  in  1 each  instruction writes a register / instruction is a load.
REQ-007 id_imm  in  32  extended immediate.
REQ-008 regfile_out1, regfile_out2  in  32 each  register file read data for id_rs / id_rt.
REQ-009 exmem_regwr, exmem_dst, exmem_data  in  1/5/32  EX/MEM result bypass.
REQ-010 memwb_regwr, memwb_dst, memwb_data  in  1/5/32  MEM/WB bypass; same signals as the register file write port.
REQ-011 flush  in  1  squash the decode slot (taken branch/jump).
REQ-012 stall  out  1  combinational; holds PC and IF/ID when 1.
REQ-013 ex_valid, ex_regwr, ex_memrd  out  1 each  registered control to EX.
REQ-014 ex_a, ex_b, ex_imm  out  32 each  registered operands.
REQ-015 ex_dst  out  5  registered destination index.
REQ-016 stall_count  out  16  saturating count of stall cycles.

Function
REQ-017 Operand select for id_rs, first match wins:
- rs==0 -> 0
- exmem_regwr && exmem_dst==rs -> exmem_data
- memwb_regwr && memwb_dst==rs -> memwb_data
- otherwise regfile_out1.
REQ-018 Operand select for id_rt uses the same priority, with regfile_out2 as the fallback.
REQ-019 The MEM/WB bypass covers the same-edge register file write; there is no read-after-write gap.
REQ-020 hazard = id_valid && ex_valid && ex_regwr && ex_dst!=0 && (ex_dst==id_rs || ex_dst==id_rt).
- Covers both load-use and ALU-use dependences; EX results are never bypassed into this stage.
REQ-021 stall = hazard && !flush; purely combinational, no registered delay.
REQ-022 Each rising edge with rst_n=1, exactly one of the following applies, in priority order:
- flush=1 -> bubble
- hazard=1 -> bubble
- otherwise -> load.
REQ-023 Bubble: ex_valid=0, ex_regwr=0, ex_memrd=0, ex_dst=0; ex_a, ex_b, ex_imm are don't-care and hold their previous value.
REQ-024 Load: ex_valid<=id_valid; ex_regwr<=id_regwr&id_valid; ex_memrd<=id_memrd&id_valid; ex_dst, ex_imm, ex_a, ex_b take the id_* fields and selected operands.
REQ-025 Latency is 1 cycle from decode to EX. A stall lasts exactly 1 cycle per dependence, because the bubble clears ex_valid on the next edge.
REQ-026 Any instruction with id_dst==0 is loaded with ex_regwr forced to 0.
REQ-027 stall_count increments on each edge where stall=1 and saturates at 16'hFFFF with no wrap.
REQ-028 flush and hazard in the same cycle: flush wins, stall=0, and stall_count does not increment.
REQ-029 id_valid=0 never raises stall.

Reset
REQ-030 While rst_n=0, independent of clk:
- ex_valid, ex_regwr, ex_memrd = 0
- ex_dst = 0
- ex_a, ex_b, ex_imm = 0
- stall_count = 0.
REQ-031 stall reads 0 during reset, since ex_valid=0.
REQ-032 Reset asserted mid-stall discards the in-flight instruction. The first edge after release performs a normal load.

Verification
REQ-033 No dependence: id rs=3/rt=4 with regfile_out 0x11/0x22 -> next edge ex_a=0x11, ex_b=0x22, ex_valid=1, stall=0.
REQ-034 Bypass priority: rs=5, exmem (1,5,0xAAAA), memwb (1,5,0xBBBB) -> ex_a=0xAAAA. With exmem_regwr=0 -> ex_a=0xBBBB. With rs=0 -> ex_a=0.
REQ-035 Load-use: EX holds a load to r7; ID reads r7 -> stall=1 for one cycle, then a bubble (ex_valid=0). Next cycle stall=0, the dependent instruction loads, and stall_count=1.
REQ-036 Flush over hazard: hazard present and flush=1 -> stall=0, next ex_valid=0, stall_count unchanged.
REQ-037 Saturation: preload 0xFFFE, then 3 stall cycles -> stall_count=0xFFFF.
REQ-038 Async reset: drop rst_n between edges while ex_valid=1 -> outputs reach 0 before the next edge. After release, the first edge performs a normal load.
